// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; optional frame counter under VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CLK_DIV     = 2,
    parameter int CELL_W_LOG2 = 4,
    parameter int CELL_H_LOG2 = 5,
    parameter int PIPE        = 1,
    parameter int XW          = 10,
    parameter int YW          = 10
) (
    input  logic                      master_clk,
    input  logic                      reset_n,
    input  logic                      power,
    output logic                      pix_ce,
    output logic                      DAC_clk,
    output logic [XW-1:0]             xPixel,
    output logic [YW-1:0]             yPixel,
    output logic [XW-CELL_W_LOG2-1:0] col,
    output logic [YW-CELL_H_LOG2-1:0] row,
    output logic [CELL_W_LOG2-1:0]    cell_x,
    output logic [CELL_H_LOG2-1:0]    cell_y,
    output logic                      display_area,
    output logic                      VGA_hSync,
    output logic                      VGA_vSync,
    output logic                      blank_n,
    output logic                      line_start,
    output logic                      frame_start,
    output logic [7:0]                frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]   div;
    logic            act, hs, vs;
    logic [PIPE-1:0] act_sr, hs_sr, vs_sr;

    // Pixel-rate divider; pix_ce is registered so it fires the cycle after div hits its last count
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else if (!power) begin
            div    <= '0;
            pix_ce <= 1'b0;
        end else begin
            pix_ce <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
        end
    end

    assign DAC_clk = (div >= DIV_HALF);

    // Raster counters; x and y wrap on the same pixel tick at frame end
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            xPixel <= '0;
            yPixel <= '0;
        end else if (!power) begin
            xPixel <= '0;
            yPixel <= '0;
        end else if (pix_ce) begin
            if (xPixel == X_LAST) begin
                xPixel <= '0;
                yPixel <= (yPixel == Y_LAST) ? '0 : yPixel + Y_ONE;
            end else begin
                xPixel <= xPixel + X_ONE;
            end
        end
    end

    // Region decode of the current raster position
    always_comb begin
        act = (xPixel < X_ACT) && (yPixel < Y_ACT);
        hs  = (xPixel >= HS_BEG) && (xPixel < HS_END);
        vs  = (yPixel >= VS_BEG) && (yPixel < VS_END);
    end

    // Delay line keeps sync/blank aligned with downstream font/colour pipelines
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else if (!power) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else if (pix_ce) begin
            act_sr[0] <= act;
            hs_sr[0]  <= hs;
            vs_sr[0]  <= vs;
            for (int i = 1; i < PIPE; i++) begin
                act_sr[i] <= act_sr[i-1];
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
            end
        end
    end

    assign display_area = act_sr[PIPE-1];
    assign blank_n      = act_sr[PIPE-1];
    assign VGA_hSync    = hs_sr[PIPE-1] ? HS_POL : ~HS_POL;
    assign VGA_vSync    = vs_sr[PIPE-1] ? VS_POL : ~VS_POL;

    assign col    = xPixel[XW-1:CELL_W_LOG2];
    assign row    = yPixel[YW-1:CELL_H_LOG2];
    assign cell_x = xPixel[CELL_W_LOG2-1:0];
    assign cell_y = yPixel[CELL_H_LOG2-1:0];

    assign line_start  = pix_ce && (xPixel == '0);
    assign frame_start = pix_ce && (xPixel == '0) && (yPixel == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Free-running frame count, wraps 255 -> 0
    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
        end else if (!power) begin
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator, successor to the fixed 640x480 sync generator in the VGA controller. Derives a pixel-rate clock enable from `master_clk`, runs programmable horizontal/vertical counters, and emits sync, blank and display-area strobes. Also emits character-cell coordinates (column/row plus in-cell offsets) for frame-buffer and font lookup. Sync and blank outputs carry a programmable pipeline delay so they stay aligned with downstream font/colour pipelines.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, asserted level of `VGA_hSync`
- `VS_POL`, 0, asserted level of `VGA_vSync`
- `CLK_DIV`, 2, `master_clk` cycles per pixel; even, ≥2
- `CELL_W_LOG2`, 4, log2 of character cell width
- `CELL_H_LOG2`, 5, log2 of character cell height
- `PIPE`, 1, pixel ticks of delay on sync/blank outputs; ≥1
- `XW`, 10, width of x counter
- `YW`, 10, width of y counter

Ports:
- `master_clk`  in  1  system clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `power`  in  1  run enable; low means synchronous idle
- `pix_ce`  out  1  one-`master_clk` pulse per pixel
- `DAC_clk`  out  1  pixel-rate square wave for the DAC
- `xPixel`  out  XW  current horizontal count
- `yPixel`  out  YW  current vertical count
- `col`  out  XW-CELL_W_LOG2  `xPixel >> CELL_W_LOG2`
- `row`  out  YW-CELL_H_LOG2  `yPixel >> CELL_H_LOG2`
- `cell_x`  out  CELL_W_LOG2  low bits of `xPixel`
- `cell_y`  out  CELL_H_LOG2  low bits of `yPixel`
- `display_area`  out  1  active video, delayed by `PIPE`
- `VGA_hSync`  out  1  horizontal sync, delayed by `PIPE`
- `VGA_vSync`  out  1  vertical sync, delayed by `PIPE`
- `blank_n`  out  1  equals `display_area`
- `line_start`  out  1  pulse when `xPixel`=0
- `frame_start`  out  1  pulse when `xPixel`=0 and `yPixel`=0
- `frame_cnt`  out  8  frame counter (macro-dependent)

## Operation
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Divider `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_ce` is registered; high for the single cycle after `div` reaches CLK_DIV-1.
  - `DAC_clk`=1 while `div`≥CLK_DIV/2.
- On `pix_ce`, `xPixel` increments; at H_TOTAL-1 it wraps to 0.
- `yPixel` increments on x wrap; at V_TOTAL-1 it wraps to 0.
- Decodes from the current (x,y):
  - act = x<H_ACTIVE && y<V_ACTIVE
  - hs = H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC
- act/hs/vs enter a `PIPE`-deep shift register advanced only on `pix_ce`.
  - Sync outputs drive the POL level when asserted and ~POL otherwise.
- `col`/`row`/`cell_x`/`cell_y` are combinational slices of the counters, so they have zero delay.
- `line_start` and `frame_start` are combinational: `pix_ce` & (x==0) [& (y==0)].
- `power` low (synchronous):
  - `div`, x and y clear to 0.
  - Pipeline flushes to inactive; `pix_ce`=0.
  - After `power` rises, the first `pix_ce` occurs CLK_DIV cycles later, with the counters starting at (0,0).

## Timing
- Reset values:
  - `pix_ce`=0, `DAC_clk`=0, x=y=0.
  - `display_area`=`blank_n`=0.
  - `VGA_hSync`=~HS_POL, `VGA_vSync`=~VS_POL, `frame_cnt`=0.
- Reset asserted mid-frame returns all outputs to these values immediately (asynchronous).
- The sync/blank output visible after the k-th `pix_ce` edge corresponds to the counter value at edge k-PIPE.
- x wrap and y wrap occur on the same edge; there is no extra cycle at frame end.
- Frame period: H_TOTAL·V_TOTAL `pix_ce` pulses, i.e. H_TOTAL·V_TOTAL·CLK_DIV `master_clk` cycles.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` increments on each `frame_start` and wraps 255→0.
  - It clears on reset and while `power` is low.
- Not defined: `frame_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset and power:
  - Hold `reset_n`=0 → all outputs at their reset values; `VGA_hSync`=`VGA_vSync`=1 with defaults.
  - Release with `power`=1 → first `pix_ce` 2 cycles later.
- Horizontal sync (defaults, PIPE=1) → `VGA_hSync` low for exactly 96 `pix_ce` pulses, covering counts x=656..751 delivered one tick late.
  - `display_area` high for 640 pulses per active line.
- Frame period (defaults) → consecutive `frame_start` pulses 840000 `master_clk` cycles apart.
  - `VGA_vSync` low for 2 lines (1600 pulses) starting at y=490.
- Cell decode at x=37, y=70 → `col`=2, `cell_x`=5, `row`=2, `cell_y`=6.
  - At x=799 → next `pix_ce` gives x=0, y incremented, `line_start`=1.
- Mid-frame stop: drop `power` at (300,200) → counters 0, `display_area`=0, syncs inactive on the next cycle.
  - Re-raise `power` → `frame_start` on the first `pix_ce`.
- With `VGA_TIMING_FRAME_CNT_EN`: run 256 frames → `frame_cnt` returns to 0.
  - Without the macro → `frame_cnt` stays 0.
- Non-default timing (CLK_DIV=4, PIPE=3, H_ACTIVE=320, HS_POL=1):
  - `pix_ce` every 4 cycles.
  - `VGA_hSync` high for H_SYNC pulses, lagging by 3 ticks.
